pwm_leds: RTL and testbench
===========================

// Module: pwm_leds
// PURPOSE
//  Memory-mapped 8-channel PWM peripheral on the shared SoC memory bus.
//  It is selected by the top-level address decoder at 0x0004_0000-0x0004_000F.
//  It drives the board LEDs with per-channel 8-bit duty cycles, replacing the plain LED latch.
//  Single-cycle bus slave, same handshake as the uart/timer peripherals.
// PARAMETERS
//  CHANNELS   8   number of PWM outputs (1..8; duty bytes beyond CHANNELS read 0, writes ignored)
//  PRESCALE_W 8   width of prescaler reload field and counter
// PORTS
//  clk             in   1   system clock (PLL clock)
//  reset_n         in   1   synchronous, active-low reset
//  address_in      in   32  bus address; only [3:2] decoded
//  sel_in          in   1   window select from top-level decoder
//  read_in         in   1   read strobe (informational; reads have no side effects)
//  read_value_out  out  32  read data; 0 when sel_in=0
//  write_mask_in   in   4   byte-lane write enables
//  write_value_in  in   32  write data
//  ready_out       out  1   access complete
//  pwm_out         out  8   PWM outputs to LED pins, registered
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-low.
//  Reset values: all registers 0; pwm_out=0.
//  Bus handshake:
//   - ready_out = sel_in, combinational; zero wait states.
//   - read_value_out is combinational from the registers, gated by sel_in.
//  Register map, word offset = address_in[3:2]:
//   0x0 CTRL:    [0] EN, [15:8] PRESC. Other bits read 0.
//   0x4 DUTY_LO: byte n = shadow duty of ch n (n=0..3).
//   0x8 DUTY_HI: byte n = shadow duty of ch n+4.
//   0xC STATUS:  [7:0] period counter, [8] PEND. Read-only; writes ignored.
//  Writes:
//   - A write occurs on sel_in && write_mask_in[b]; it updates byte b only, effective next cycle.
//   - A write to any DUTY byte sets PEND.
//  Prescaler:
//   - pcnt counts up while EN=1.
//   - When pcnt >= PRESC: tick=1 and pcnt <= 0. One tick per PRESC+1 cycles; PRESC=0 gives a tick every cycle.
//   - Lowering PRESC below the current pcnt produces a tick on the next cycle (>= compare), never a 2^8 wrap.
//  Period counter:
//   - 8-bit cnt increments on tick, wrapping 255->0. Period = 256 ticks.
//  Duty update:
//   - Active duty is loaded from shadow only on the tick where cnt wraps 255->0. This load clears PEND.
//   - Glitch-free: no mid-period change of active duty.
//   - Write on the same cycle as the wrap tick: active loads the pre-write shadow; PEND stays 1 and the new value is applied at the next wrap.
//  Output:
//   - pwm_out[i] <= EN && (cnt < active_duty[i]), registered, so pwm_out lags cnt by 1 cycle.
//   - duty 0 gives constant 0; duty 255 gives high for 255 of 256 ticks.
//  EN=0:
//   - pcnt and cnt held at 0; pwm_out forced 0 on the next edge.
//   - Active duty tracks shadow continuously and PEND reads 0, so the first period after EN 0->1 uses the latest duty.
//  Reset mid-period: everything returns to reset values in 1 edge; no partial period is emitted.
// STRUCTURE
//  pwm_pkg:
//   - register offsets: CTRL_OFF, DUTY_LO_OFF, DUTY_HI_OFF, STATUS_OFF
//   - field bit positions: EN_BIT, PRESC_LSB
//   - DUTY_W=8
//   - typedef duty_t
//  Sub-module pwm_prescaler (EN, PRESC in; tick out).
//  Per-channel compare stays inline (generate loop).
// TESTING
//  1. Reset: hold reset_n=0 for 3 cycles -> pwm_out=0; reads of all 4 offsets return 0; ready_out follows sel_in.
//  2. CTRL=0x0000_0001 (PRESC=0), DUTY_LO=0x0000_0040 -> after the first wrap, ch0 is high for 64 of every 256 cycles; ch1-7 stay low.
//  3. PRESC=3, duty0=0x80 -> period 1024 cycles, ch0 high 512; STATUS[7:0] increments every 4 cycles.
//  4. Write DUTY_LO byte0=0xFF on the exact wrap-tick cycle -> PEND=1; old duty used for one more period; 0xFF applied at the next wrap; PEND=0.
//  5. Byte-lane write: mask=4'b0100, value=0x00AA_0000 to DUTY_HI -> only ch6 shadow=0xAA; other bytes unchanged.
//  6. Clear EN mid-period (cnt=100) -> pwm_out=0 next cycle; STATUS=0; re-enable -> new period starts from cnt=0 with the latest shadow duty.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants and types for the pwm_leds peripheral: register offsets,
// field positions and the duty-cycle byte type.
package pwm_pkg;

  localparam int unsigned DUTY_W    = 8;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned MAX_CH    = 8;

  localparam logic [1:0] CTRL_OFF    = 2'd0;
  localparam logic [1:0] DUTY_LO_OFF = 2'd1;
  localparam logic [1:0] DUTY_HI_OFF = 2'd2;
  localparam logic [1:0] STATUS_OFF  = 2'd3;

  localparam int unsigned EN_BIT    = 0;
  localparam int unsigned PRESC_LSB = 8;
  localparam int unsigned PEND_BIT  = 8;

  typedef logic [DUTY_W-1:0] duty_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one tick every presc_i+1 cycles while enabled, counter
// parked at zero otherwise.
module pwm_prescaler #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [W-1:0] presc_i,
  output logic         tick_c_o
);

  logic [W-1:0] pcnt_q, pcnt_d;

  // >= compare so a reload lowered below pcnt ticks at once instead of wrapping
  always_comb begin
    tick_c_o = 1'b0;
    pcnt_d   = pcnt_q;
    if (!en_i) begin
      pcnt_d = '0;
    end else if (pcnt_q >= presc_i) begin
      tick_c_o = 1'b1;
      pcnt_d   = '0;
    end else begin
      pcnt_d = pcnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) pcnt_q <= '0;
    else          pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/pwm_leds.sv
// Memory-mapped 8-channel LED PWM with shadowed duty registers that are
// committed only at the period wrap, so outputs never glitch mid-period.
module pwm_leds
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS   = 8,
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [7:0]  pwm_out
);

  logic                      en_q, en_d;
  logic [PRESCALE_W-1:0]     presc_q, presc_d;
  duty_t [CHANNELS-1:0]      shadow_q, shadow_d;
  duty_t [CHANNELS-1:0]      active_q, active_d;
  logic                      pend_q, pend_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [MAX_CH-1:0]         pwm_q, pwm_d;
  logic                      tick_c, wrap_c, duty_wr_c;
  logic [1:0]                offset_c;
  logic [31:0]               read_c;
  logic                      unused_c;

  assign offset_c = address_in[3:2];
  assign unused_c = ^{read_in, address_in[31:4], address_in[1:0], write_value_in[7:1]};

  pwm_prescaler #(.W(PRESCALE_W)) u_presc (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_i     (en_q),
    .presc_i  (presc_q),
    .tick_c_o (tick_c)
  );

  // Register writes, byte-lane granular
  always_comb begin
    en_d      = en_q;
    presc_d   = presc_q;
    shadow_d  = shadow_q;
    duty_wr_c = 1'b0;
    if (sel_in) begin
      case (offset_c)
        CTRL_OFF: begin
          if (write_mask_in[0]) en_d = write_value_in[EN_BIT];
          if (write_mask_in[1]) presc_d = write_value_in[PRESC_LSB +: PRESCALE_W];
        end
        DUTY_LO_OFF: begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (write_mask_in[b] && (b < CHANNELS)) begin
              shadow_d[b] = write_value_in[8*b +: 8];
              duty_wr_c   = 1'b1;
            end
          end
        end
        DUTY_HI_OFF: begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (write_mask_in[b] && ((b + 4) < CHANNELS)) begin
              shadow_d[b+4] = write_value_in[8*b +: 8];
              duty_wr_c     = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Period counter and shadow->active commit; disabled mode tracks the shadow
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    pend_d   = pend_q;
    pwm_d    = '0;
    wrap_c   = tick_c && (cnt_q == '1);
    if (!en_q) begin
      cnt_d    = '0;
      active_d = shadow_d;
      pend_d   = 1'b0;
    end else begin
      if (tick_c) cnt_d = cnt_q + CNT_W'(1);
      if (wrap_c) begin
        active_d = shadow_q;
        pend_d   = duty_wr_c;
      end else if (duty_wr_c) begin
        pend_d = 1'b1;
      end
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pwm_d[i] = en_q && (cnt_q < active_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q     <= 1'b0;
      presc_q  <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      pwm_q    <= '0;
    end else begin
      en_q     <= en_d;
      presc_q  <= presc_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      pwm_q    <= pwm_d;
    end
  end

  // Read mux
  always_comb begin
    read_c = '0;
    case (offset_c)
      CTRL_OFF: begin
        read_c[EN_BIT]                   = en_q;
        read_c[PRESC_LSB +: PRESCALE_W]  = presc_q;
      end
      DUTY_LO_OFF: begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (b < CHANNELS) read_c[8*b +: 8] = shadow_q[b];
        end
      end
      DUTY_HI_OFF: begin
        for (int unsigned b = 0; b < 4; b++) begin
          if ((b + 4) < CHANNELS) read_c[8*b +: 8] = shadow_q[b+4];
        end
      end
      default: begin
        read_c[CNT_W-1:0] = cnt_q;
        read_c[PEND_BIT]  = pend_q;
      end
    endcase
  end

  assign read_value_out = sel_in ? read_c : 32'h0;
  assign ready_out      = sel_in;
  assign pwm_out        = pwm_q;

endmodule

// File: tb/tb_pwm_leds.sv
// Directed self-checking bench for pwm_leds: register access, duty timing,
// wrap-synchronous commit, byte lanes and enable/disable behaviour.
module tb_pwm_leds;

  localparam logic [31:0] A_CTRL   = 32'h0004_0000;
  localparam logic [31:0] A_DLO    = 32'h0004_0004;
  localparam logic [31:0] A_DHI    = 32'h0004_0008;
  localparam logic [31:0] A_STATUS = 32'h0004_000C;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address_in;
  logic        sel_in;
  logic        read_in;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in;
  logic [31:0] write_value_in;
  logic        ready_out;
  logic [7:0]  pwm_out;

  int tests = 0;
  int fails = 0;
  int hi_cnt [8];

  always #5 clk = ~clk;

  pwm_leds dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .address_in     (address_in),
    .sel_in         (sel_in),
    .read_in        (read_in),
    .read_value_out (read_value_out),
    .write_mask_in  (write_mask_in),
    .write_value_in (write_value_in),
    .ready_out      (ready_out),
    .pwm_out        (pwm_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic bus_write(input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
    address_in     = addr;
    sel_in         = 1'b1;
    read_in        = 1'b0;
    write_mask_in  = mask;
    write_value_in = data;
    @(negedge clk);
    sel_in        = 1'b0;
    write_mask_in = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    address_in    = addr;
    sel_in        = 1'b1;
    read_in       = 1'b1;
    write_mask_in = 4'h0;
    #1;
    data    = read_value_out;
    sel_in  = 1'b0;
    read_in = 1'b0;
  endtask

  task automatic count_high(input int ncyc);
    for (int c = 0; c < 8; c++) hi_cnt[c] = 0;
    for (int k = 0; k < ncyc; k++) begin
      for (int c = 0; c < 8; c++) hi_cnt[c] += int'(pwm_out[c]);
      @(negedge clk);
    end
  endtask

  task automatic wait_cnt(input logic [7:0] target, output bit found);
    logic [31:0] d;
    found = 1'b0;
    for (int i = 0; i < 1100 && !found; i++) begin
      bus_read(A_STATUS, d);
      if (d[7:0] == target) found = 1'b1;
      else @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit          found;

    reset_n = 1'b0; address_in = '0; sel_in = 1'b0; read_in = 1'b0;
    write_mask_in = '0; write_value_in = '0;

    // 1. Reset
    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(pwm_out), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(A_CTRL, rd);   check("reset_ctrl", rd, 32'h0);
    bus_read(A_DLO, rd);    check("reset_dlo", rd, 32'h0);
    bus_read(A_DHI, rd);    check("reset_dhi", rd, 32'h0);
    bus_read(A_STATUS, rd); check("reset_status", rd, 32'h0);
    sel_in = 1'b1; #1; check("ready_hi", 32'(ready_out), 32'h1);
    sel_in = 1'b0; #1; check("ready_lo", 32'(ready_out), 32'h0);
    @(negedge clk);

    // 2. PRESC=0, duty0=0x40
    bus_write(A_DLO, 4'hF, 32'h0000_0040);
    bus_read(A_DLO, rd); check("dlo_readback", rd, 32'h0000_0040);
    bus_write(A_CTRL, 4'hF, 32'h0000_0001);
    count_high(256);
    check("t2_ch0_high", 32'(hi_cnt[0]), 32'd64);
    check("t2_other_high", 32'(hi_cnt[1] + hi_cnt[2] + hi_cnt[3] + hi_cnt[4]
                               + hi_cnt[5] + hi_cnt[6] + hi_cnt[7]), 32'd0);

    // 3. PRESC=3, duty0=0x80; other CTRL bits read 0
    bus_write(A_CTRL, 4'hF, 32'h0);
    bus_write(A_DLO, 4'h1, 32'h0000_0080);
    bus_write(A_CTRL, 4'hF, 32'hFFFF_0301);
    bus_read(A_CTRL, rd);   check("ctrl_fields", rd, 32'h0000_0301);
    bus_read(A_STATUS, rd); check("t3_status0", rd, 32'h0);
    repeat (4) @(negedge clk);
    bus_read(A_STATUS, rd); check("t3_status1", rd, 32'h1);
    repeat (4) @(negedge clk);
    bus_read(A_STATUS, rd); check("t3_status2", rd, 32'h2);
    count_high(1024);
    check("t3_ch0_high", 32'(hi_cnt[0]), 32'd512);

    // 4. Duty write on the wrap-tick cycle
    bus_write(A_CTRL, 4'hF, 32'h0);
    bus_write(A_DLO, 4'h1, 32'h0000_0040);
    bus_write(A_CTRL, 4'hF, 32'h0000_0001);
    wait_cnt(8'd255, found);
    check("t4_found_wrap", 32'(found), 32'h1);
    bus_write(A_DLO, 4'h1, 32'h0000_00FF);
    bus_read(A_STATUS, rd); check("t4_pend_set", rd, 32'h100);
    count_high(256);
    check("t4_old_duty", 32'(hi_cnt[0]), 32'd64);
    bus_read(A_STATUS, rd); check("t4_pend_clr", rd, 32'h0);
    count_high(256);
    check("t4_new_duty", 32'(hi_cnt[0]), 32'd255);

    // 5. Byte lanes, read-only STATUS, unselected read
    bus_write(A_DHI, 4'hF, 32'h4433_2211);
    bus_write(A_DHI, 4'b0100, 32'h00AA_0000);
    bus_read(A_DHI, rd); check("t5_dhi_lane", rd, 32'h44AA_2211);
    bus_read(A_DLO, rd); check("t5_dlo_keep", rd, 32'h0000_00FF);
    bus_write(A_STATUS, 4'hF, 32'hFFFF_FFFF);
    bus_read(A_CTRL, rd); check("t5_status_ro", rd, 32'h0000_0001);
    address_in = A_CTRL; sel_in = 1'b0; #1;
    check("t5_unsel_read", read_value_out, 32'h0);

    // 6. Disable at cnt=100, update duty, re-enable
    @(negedge clk);
    wait_cnt(8'd100, found);
    check("t6_found_100", 32'(found), 32'h1);
    bus_write(A_CTRL, 4'hF, 32'h0);
    @(negedge clk);
    check("t6_pwm_off", 32'(pwm_out), 32'h0);
    bus_read(A_STATUS, rd); check("t6_status_off", rd, 32'h0);
    bus_write(A_DLO, 4'h1, 32'h0000_0010);
    bus_read(A_STATUS, rd); check("t6_pend_dis", rd, 32'h0);
    bus_write(A_CTRL, 4'hF, 32'h0000_0001);
    bus_read(A_STATUS, rd); check("t6_restart", rd, 32'h0);
    count_high(256);
    check("t6_ch0_high", 32'(hi_cnt[0]), 32'd16);
    check("t6_ch4_high", 32'(hi_cnt[4]), 32'd17);
    check("t6_ch6_high", 32'(hi_cnt[6]), 32'd170);
    check("t6_ch7_high", 32'(hi_cnt[7]), 32'd68);
    check("t6_ch1_high", 32'(hi_cnt[1]), 32'd0);

    // Reset mid-period
    repeat (37) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("rst_mid_pwm", 32'(pwm_out), 32'h0);
    bus_read(A_STATUS, rd); check("rst_mid_status", rd, 32'h0);
    bus_read(A_CTRL, rd);   check("rst_mid_ctrl", rd, 32'h0);
    bus_read(A_DHI, rd);    check("rst_mid_dhi", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
